alu_pipe2: RTL

Two-stage registered ALU with valid/ready handshaking on both sides. It accepts one operation per cycle from the operand issue logic, registers the operands, computes and registers the result with carry and zero flags, and presents it to the downstream result consumer. It is the back-pressured, flag-producing successor to the combinational ALU and single-register pipeline, and it sits between operand issue and the result/writeback stage.

---
 rtl/alu_pipe2.sv | 81 ++++++++
 1 files changed

// File: rtl/alu_pipe2.sv
// Two-stage registered add/sub ALU with carry and zero flags.
// Valid/ready handshake on both sides; no skid buffer.
module alu_pipe2 #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_carry,
   output logic             out_zero,
   output logic [CNT_W-1:0] done_count
);

   logic             s1_valid;
   logic [1:0]       s1_op;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic             s2_take;
   logic [WIDTH:0]   alu_full;

   assign s2_take  = !out_valid || out_ready;
   assign in_ready = !s1_valid || s2_take;

   // Bit WIDTH is carry-out for add and borrow (a < b) for sub.
   always_comb begin
      alu_full = '0;
      unique case (s1_op)
         2'b00:   alu_full = {1'b0, s1_a} + {1'b0, s1_b};
         2'b01:   alu_full = {1'b0, s1_a} - {1'b0, s1_b};
         default: alu_full = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_op    <= '0;
         s1_a     <= '0;
         s1_b     <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_op <= in_op;
            s1_a  <= in_a;
            s1_b  <= in_b;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_result <= '0;
         out_carry  <= 1'b0;
         out_zero   <= 1'b0;
      end else if (s2_take) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_result <= alu_full[WIDTH-1:0];
            out_carry  <= alu_full[WIDTH];
            out_zero   <= (alu_full[WIDTH-1:0] == '0);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         done_count <= '0;
      else if (out_valid && out_ready)
         done_count <= done_count + 1'b1;
   end

endmodule
